ladybird_uart_tx_fifo: RTL and testbench

Byte FIFO that sits directly upstream of the UART transmitter. It decouples a bursty byte producer (CPU MMIO store or debug engine) from the serial line rate. The read side drives the transmitter's valid/data/ready handshake with first-word-fall-through semantics. Status outputs (count, empty, full, sticky overflow) are for MMIO status registers.

---
 rtl/ladybird_uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_ladybird_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: first-word-fall-through read side,
// explicit occupancy counter, sticky overflow flag for MMIO status.
module ladybird_uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  // Status derives only from registered count, so wr_ready never sees rd_ready
  // and rd_valid/rd_data never see the write inputs.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign rd_data  = mem_q[rptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wr_data;
        wptr_d        = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Set takes precedence over a same-cycle clear.
      if (wr_valid && !wr_ready) begin
        overflow_d = 1'b1;
      end else if (clr_overflow) begin
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_ladybird_uart_tx_fifo.sv
// Directed bench for ladybird_uart_tx_fifo, including a small UART transmitter
// model on the read side whose serial line is decoded independently.
module tb_ladybird_uart_tx_fifo;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic       rd_ready_man = 1'b0;
  logic [4:0] count;
  logic       empty, full, overflow;
  logic       clr_overflow = 1'b0;

  logic       tx_en = 1'b0;
  logic       tx_busy = 1'b0;
  logic [9:0] tx_sh = '1;
  int         tx_tmr = 0;
  int         tx_bit = 0;
  int         tx_pops = 0;
  logic       tx_line;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ladybird_uart_tx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  // Transmitter model: ready while idle, one start bit, 8 data bits LSB first, one stop bit.
  assign rd_ready = tx_en ? ~tx_busy : rd_ready_man;
  assign tx_line  = tx_busy ? tx_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (tx_en && rd_valid && rd_ready) tx_pops <= tx_pops + 1;
    if (!tx_busy) begin
      if (tx_en && rd_valid) begin
        tx_sh   <= {1'b1, rd_data, 1'b0};
        tx_busy <= 1'b1;
        tx_tmr  <= 0;
        tx_bit  <= 0;
      end
    end else if (tx_tmr == W - 1) begin
      tx_tmr <= 0;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      tx_bit <= tx_bit + 1;
      if (tx_bit == 9) tx_busy <= 1'b0;
    end else begin
      tx_tmr <= tx_tmr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] b);
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, b);
    rd_ready_man = 1'b1;
    step();
    rd_ready_man = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] exp);
    int n;
    logic [7:0] b;
    n = 0;
    b = '0;
    while (tx_line !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("rx_start_seen", 32'(n < 200), 32'd1);
    step();
    chk("rx_start_bit", tx_line, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (W) step();
      b[i] = tx_line;
    end
    repeat (W) step();
    chk("rx_stop_bit", tx_line, 1'b1);
    chk("rx_byte", b, exp);
  endtask

  initial begin
    int pops0;

    // Reset state
    rst = 1'b1;
    step();
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    step();

    // Single byte latency and hold under backpressure
    push(8'h55);
    chk("one_count", count, 5'd1);
    chk("one_rd_valid", rd_valid, 1'b1);
    chk("one_rd_data", rd_data, 8'h55);
    step();
    step();
    chk("hold_rd_data", rd_data, 8'h55);
    chk("hold_count", count, 5'd1);
    pop_expect("one_pop", 8'h55);
    chk("one_empty", empty, 1'b1);

    // Fill to full
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_flag", full, 1'b1);
    chk("full_wr_ready", wr_ready, 1'b0);
    chk("full_count", count, 5'd16);
    chk("full_head", rd_data, 8'h00);

    // Write while full with a pop: byte dropped, overflow set
    wr_valid = 1'b1; wr_data = 8'hAA; rd_ready_man = 1'b1;
    step();
    wr_valid = 1'b0; rd_ready_man = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", count, 5'd15);
    step();
    chk("ovf_sticky", overflow, 1'b1);
    for (int i = 1; i < 16; i++) pop_expect("drain_a", 8'(i));
    chk("drain_a_empty", empty, 1'b1);
    chk("drain_a_rd_valid", rd_valid, 1'b0);
    chk("ovf_still", overflow, 1'b1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Set and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    wr_valid = 1'b1; wr_data = 8'hBB; clr_overflow = 1'b1;
    step();
    wr_valid = 1'b0; clr_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1'b1);
    chk("ovf_set_wins_count", count, 5'd16);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr2", overflow, 1'b0);

    // Down to 5 entries, then steady push+pop across pointer wraps
    for (int i = 0; i < 11; i++) pop_expect("drain_b", 8'h10 + 8'(i));
    chk("five_count", count, 5'd5);
    wr_valid = 1'b1; rd_ready_man = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'h20 + 8'(i);
      chk("stream_data", rd_data, 8'h1B + 8'(i));
      step();
    end
    wr_valid = 1'b0; rd_ready_man = 1'b0;
    chk("stream_count", count, 5'd5);
    for (int i = 0; i < 5; i++) pop_expect("drain_c", 8'h43 + 8'(i));
    chk("drain_c_empty", empty, 1'b1);

    // Transmitter-driven reads of "Hi\n"
    pops0 = tx_pops;
    tx_en = 1'b1;
    push(8'h48);
    push(8'h69);
    push(8'h0A);
    rx_frame(8'h48);
    rx_frame(8'h69);
    rx_frame(8'h0A);
    repeat (2 * W) step();
    chk("tx_pops", 32'(tx_pops - pops0), 32'd3);
    chk("tx_empty", empty, 1'b1);
    tx_en = 1'b0;
    step();

    // Flush at count 7 with a push; overflow unaffected
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    push(8'hCC);
    chk("ovf_pre_flush", overflow, 1'b1);
    for (int i = 0; i < 9; i++) pop_expect("drain_d", 8'h80 + 8'(i));
    chk("seven_count", count, 5'd7);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_count", count, 5'd0);
    chk("flush_empty", empty, 1'b1);
    chk("flush_rd_valid", rd_valid, 1'b0);
    chk("flush_overflow", overflow, 1'b1);

    // Pop requests on empty are ignored
    rd_ready_man = 1'b1;
    step();
    rd_ready_man = 1'b0;
    chk("empty_pop_count", count, 5'd0);
    push(8'h90);
    push(8'h91);
    push(8'h92);
    chk("three_count", count, 5'd3);
    chk("three_head", rd_data, 8'h90);

    // Reset with a simultaneous pop
    rst = 1'b1; rd_ready_man = 1'b1;
    step();
    rst = 1'b0; rd_ready_man = 1'b0;
    chk("rst2_count", count, 5'd0);
    chk("rst2_empty", empty, 1'b1);
    chk("rst2_rd_valid", rd_valid, 1'b0);
    chk("rst2_overflow", overflow, 1'b0);
    step();
    chk("rst2_quiet", rd_valid, 1'b0);
    push(8'h77);
    chk("post_rst_data", rd_data, 8'h77);
    chk("post_rst_count", count, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
